// File: rtl/register_file_if.sv
// Bus bundle between the write-back/decode stages and the register file:
// write port, two read ports, pending-load scoreboard and decode stall.
interface register_file_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              pend_set;
  logic [ADDR_W-1:0] pend_addr;
  logic              stall;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, pend_set, pend_addr,
    input  rd_data_a, rd_data_b, stall
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, pend_set, pend_addr,
    output rd_data_a, rd_data_b, stall
  );
endinterface

// File: rtl/register_file.sv
// 16 x 20-bit architectural register file: r0 hardwired to zero, two bypassed
// combinational read ports, one write port and a pending-load stall scoreboard.
module register_file #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  register_file_if.slave rf
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
  localparam logic [NREG-1:0]   ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs_r [NREG];
  logic [NREG-1:0]   pend_r;
  logic [NREG-1:0]   pend_nxt_s;
  logic [NREG-1:0]   clr_mask_s;
  logic [NREG-1:0]   set_mask_s;
  logic              wr_ok_s;
  logic              set_ok_s;
  logic [DATA_W-1:0] rd_a_s;
  logic [DATA_W-1:0] rd_b_s;
  logic              busy_a_s;
  logic              busy_b_s;

  // Read value with same-cycle write-through; index 0 always reads zero.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              w_en,
    input logic [ADDR_W-1:0] w_addr,
    input logic [DATA_W-1:0] w_data,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (addr == ZERO_IDX) begin
      val = {DATA_W{1'b0}};
    end else if (w_en && (w_addr == addr)) begin
      val = w_data;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // An operand being written this cycle is served by the bypass, so it never stalls.
  function automatic logic busy_port(
    input logic [ADDR_W-1:0] addr,
    input logic              pend_bit,
    input logic              w_en,
    input logic [ADDR_W-1:0] w_addr
  );
    return pend_bit & ~(w_en & (w_addr == addr)) & (addr != ZERO_IDX);
  endfunction

  assign wr_ok_s  = rf.wr_en & (rf.wr_addr != ZERO_IDX);
  assign set_ok_s = rf.pend_set & (rf.pend_addr != ZERO_IDX);

  // Scoreboard next state: clear on write, then set so a new load owns the register.
  always_comb begin
    clr_mask_s = {NREG{1'b0}};
    set_mask_s = {NREG{1'b0}};
    if (wr_ok_s) begin
      clr_mask_s = ONE_HOT0 << rf.wr_addr;
    end else begin
      clr_mask_s = {NREG{1'b0}};
    end
    if (set_ok_s) begin
      set_mask_s = ONE_HOT0 << rf.pend_addr;
    end else begin
      set_mask_s = {NREG{1'b0}};
    end
    pend_nxt_s = ((pend_r & ~clr_mask_s) | set_mask_s) & ~ONE_HOT0;
  end

  // Register storage; r0 stays at its reset value of zero forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_r[rf.wr_addr] <= rf.wr_data;
    end
  end

  // Pending-load scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= {NREG{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Combinational read ports and decode stall.
  always_comb begin
    rd_a_s   = {DATA_W{1'b0}};
    rd_b_s   = {DATA_W{1'b0}};
    busy_a_s = 1'b0;
    busy_b_s = 1'b0;
    rd_a_s   = read_port(rf.rd_addr_a, rf.wr_en, rf.wr_addr, rf.wr_data, regs_r[rf.rd_addr_a]);
    rd_b_s   = read_port(rf.rd_addr_b, rf.wr_en, rf.wr_addr, rf.wr_data, regs_r[rf.rd_addr_b]);
    busy_a_s = busy_port(rf.rd_addr_a, pend_r[rf.rd_addr_a], rf.wr_en, rf.wr_addr);
    busy_b_s = busy_port(rf.rd_addr_b, pend_r[rf.rd_addr_b], rf.wr_en, rf.wr_addr);
  end

  assign rf.rd_data_a = rd_a_s;
  assign rf.rd_data_b = rd_b_s;
  assign rf.stall     = busy_a_s | busy_b_s;
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a behavioural model plus directed
// expectations push entries each cycle, which are popped against the DUT outputs.
module tb_register_file;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 4;
  localparam int NREG   = 16;

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              st;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [DATA_W-1:0] m_regs [NREG];
  logic [NREG-1:0]   m_pend;
  exp_t              sb_q [$];

  register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [19:0] wd,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic ps, input logic [3:0] pa);
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    bus.pend_set  = ps;
    bus.pend_addr = pa;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_regs[i] = 20'h00000;
    m_pend = 16'h0000;
  endtask

  function automatic logic [DATA_W-1:0] m_read(input logic [3:0] addr);
    if (addr == 4'd0) return 20'h00000;
    if (bus.wr_en && bus.wr_addr == addr) return bus.wr_data;
    return m_regs[addr];
  endfunction

  function automatic logic m_busy(input logic [3:0] addr);
    if (addr == 4'd0) return 1'b0;
    return m_pend[addr] && !(bus.wr_en && bus.wr_addr == addr);
  endfunction

  task automatic push_exp(input string tag, input logic [19:0] a, input logic [19:0] b, input logic st);
    exp_t e;
    e.tag = tag;
    e.a   = a;
    e.b   = b;
    e.st  = st;
    sb_q.push_back(e);
  endtask

  task automatic push_model();
    push_exp("model", m_read(bus.rd_addr_a), m_read(bus.rd_addr_b),
             m_busy(bus.rd_addr_a) | m_busy(bus.rd_addr_b));
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({e.tag, "_rd_a"}, 32'(bus.rd_data_a), 32'(e.a));
      check_val({e.tag, "_rd_b"}, 32'(bus.rd_data_b), 32'(e.b));
      check_val({e.tag, "_stall"}, 32'(bus.stall), 32'(e.st));
    end
  endtask

  // One cycle: expectations pushed while inputs are stable, compared mid-cycle,
  // then the model commits on the same rising edge as the DUT.
  task automatic tick();
    push_model();
    #2;
    drain();
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (bus.wr_en && bus.wr_addr != 4'd0) begin
        m_regs[bus.wr_addr] = bus.wr_data;
        m_pend[bus.wr_addr] = 1'b0;
      end
      if (bus.pend_set && bus.pend_addr != 4'd0) m_pend[bus.pend_addr] = 1'b1;
    end
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    model_clear();
    drive(1'b0, 4'd0, 20'h00000, 4'd0, 4'd0, 1'b0, 4'd0);
    #1;
    push_exp("rst_init", 20'h00000, 20'h00000, 1'b0);
    tick();
    rst_n = 1'b1;

    // Write r5, bypass on both ports, then stored value next cycle.
    drive(1'b1, 4'd5, 20'hABCDE, 4'd5, 4'd5, 1'b0, 4'd0);
    push_exp("wr5_byp", 20'hABCDE, 20'hABCDE, 1'b0);
    tick();
    drive(1'b0, 4'd0, 20'h00000, 4'd5, 4'd5, 1'b0, 4'd0);
    push_exp("rd5", 20'hABCDE, 20'hABCDE, 1'b0);
    tick();

    // Writes to r0 are dropped.
    drive(1'b1, 4'd0, 20'hFFFFF, 4'd0, 4'd0, 1'b0, 4'd0);
    push_exp("wr0_same", 20'h00000, 20'h00000, 1'b0);
    tick();
    drive(1'b0, 4'd0, 20'h00000, 4'd0, 4'd5, 1'b0, 4'd0);
    push_exp("rd0", 20'h00000, 20'hABCDE, 1'b0);
    tick();

    // Bypass hides the old r7 contents.
    drive(1'b1, 4'd7, 20'h11111, 4'd0, 4'd0, 1'b0, 4'd0);
    tick();
    drive(1'b1, 4'd7, 20'h0F0F0, 4'd5, 4'd7, 1'b0, 4'd0);
    push_exp("byp7", 20'hABCDE, 20'h0F0F0, 1'b0);
    tick();

    // Scoreboard: pend r9 at cycle 0, stall cycles 1..3, write clears at cycle 4.
    drive(1'b0, 4'd0, 20'h00000, 4'd9, 4'd0, 1'b1, 4'd9);
    push_exp("pend9_c0", 20'h00000, 20'h00000, 1'b0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 4'd0, 20'h00000, 4'd9, 4'd0, 1'b0, 4'd0);
      push_exp($sformatf("pend9_c%0d", c), 20'h00000, 20'h00000, 1'b1);
      tick();
    end
    drive(1'b1, 4'd9, 20'h00042, 4'd9, 4'd0, 1'b0, 4'd0);
    push_exp("pend9_c4", 20'h00042, 20'h00000, 1'b0);
    tick();
    drive(1'b0, 4'd0, 20'h00000, 4'd9, 4'd9, 1'b0, 4'd0);
    push_exp("pend9_c5", 20'h00042, 20'h00042, 1'b0);
    tick();

    // Set/clear collision on r2: set wins.
    drive(1'b1, 4'd2, 20'h55555, 4'd2, 4'd0, 1'b1, 4'd2);
    push_exp("coll_c0", 20'h55555, 20'h00000, 1'b0);
    tick();
    drive(1'b0, 4'd0, 20'h00000, 4'd2, 4'd0, 1'b0, 4'd0);
    push_exp("coll_c1", 20'h55555, 20'h00000, 1'b1);
    tick();

    // pend_set on index 0 has no effect.
    drive(1'b0, 4'd0, 20'h00000, 4'd0, 4'd0, 1'b1, 4'd0);
    tick();
    drive(1'b0, 4'd0, 20'h00000, 4'd0, 4'd0, 1'b0, 4'd0);
    push_exp("idx0", 20'h00000, 20'h00000, 1'b0);
    tick();

    // Preload r3 + pending, then asynchronous reset mid-cycle.
    drive(1'b1, 4'd3, 20'h12345, 4'd0, 4'd0, 1'b1, 4'd3);
    tick();
    drive(1'b0, 4'd0, 20'h00000, 4'd3, 4'd3, 1'b0, 4'd0);
    push_exp("pre_rst", 20'h12345, 20'h12345, 1'b1);
    push_model();
    #2;
    drain();
    rst_n = 1'b0;
    model_clear();
    #1;
    push_exp("rst_async", 20'h00000, 20'h00000, 1'b0);
    drain();
    @(posedge clk);
    #1;
    drive(1'b1, 4'd4, 20'h0AAAA, 4'd4, 4'd3, 1'b1, 4'd4);
    push_exp("rst_byp", 20'h0AAAA, 20'h00000, 1'b0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 4'd0, 20'h00000, 4'd4, 4'd3, 1'b0, 4'd0);
    push_exp("rst_nowr", 20'h00000, 20'h00000, 1'b0);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), 20'($urandom),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
